rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides.
- Supports two modes: fixed priority (LSB wins) or round-robin priority (rotating start pointer).
- Flags multi-hot and all-zero inputs instead of emitting X.
- Sits between request-generating logic (interrupt lines, arbiter requests) and downstream index consumers.

Parameters:
- N, 8, number of request lines; legal range 2..64, power of two.
- W, 3, index width; must equal clog2(N); an elaboration-time check errors out otherwise.
- RR_MODE, 0, 0 = fixed priority with bit 0 highest; 1 = round-robin, search starts at the pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  req is valid this cycle.
- in_ready  output  1  block can accept req this cycle.
- req  input  N  request vector.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_idx  output  W  encoded index of the winning request.
- out_none  output  1  captured req was all-zero; out_idx = 0.
- out_multi  output  1  captured req had more than one bit set.

Behaviour:
- Reset (rst = 1 at a posedge) overrides everything: out_valid = 0, out_idx = 0, out_none = 0, out_multi = 0, RR pointer ptr = 0.
  - A transfer in flight is discarded.
  - in_ready is 1 in the cycle after reset.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept: in_valid && in_ready at a posedge.
  - The result is registered, so latency is 1 cycle: out_valid rises on the edge after accept.
  - Back-to-back accepts give 1 result per cycle at full throughput.
- Output: out_valid && out_ready at a posedge.
  - The result is consumed and out_valid falls unless a new accept happens on the same edge.
  - With simultaneous consume and accept, the new result replaces the old one and out_valid stays 1.
- Hold: while out_valid && !out_ready, out_idx, out_none and out_multi stay stable and no accept occurs.
- Fixed mode (RR_MODE = 0): out_idx = lowest set bit index of req.
- Round-robin mode (RR_MODE = 1):
  - out_idx = first set bit found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - On an accept with req != 0: ptr <= (out_idx_next + 1) mod N. Wrap from N-1 goes to 0.
  - On an accept with req == 0: ptr is unchanged.
  - ptr never changes without an accept.
- Fixed mode: ptr is held at 0 and is unused.
- All-zero accept: out_valid = 1, out_none = 1, out_idx = 0, out_multi = 0.
- Multi-hot accept: the priority winner is encoded and out_multi = 1.
- Exactly one-hot accept: out_none = 0, out_multi = 0. The index equals the set bit in either mode.
- Outputs are never X after reset. req is ignored when in_valid = 0.
- State: one result register, one ptr register (W bits).
- Scan implementation:
  - RR search uses a double-width (2N) masked priority scan.
  - The index is reduced mod N by truncation to W bits.

Test Plan:
- Reset and one-hot sweep, N = 8, RR_MODE = 0, out_ready = 1. Assert rst for 2 cycles, then send req = 8'h01, 8'h02, ..., 8'h80 back-to-back.
  - Required: out_idx = 0..7 one cycle after each accept, out_none = 0, out_multi = 0, in_ready constantly 1.
- Zero and multi-hot flags, N = 8, RR_MODE = 0.
  - req = 8'h00 -> out_idx = 0, out_none = 1, out_multi = 0.
  - req = 8'hA4 -> out_idx = 2, out_multi = 1, out_none = 0.
- Round-robin rotation, N = 8, RR_MODE = 1. Send req = 8'h81 four times.
  - Required: out_idx = 0, 7, 0, 7.
  - ptr after each accept: 1, 0 (wrap from 7 to 0), 1, 0.
  - Then send req = 8'h00: out_none = 1 and ptr stays 0.
- Backpressure.
  - Setup: accept req = 8'h10, then hold out_ready = 0 for 3 cycles while in_valid = 1 with req = 8'h01.
  - During the hold: in_ready = 0, out_idx stays 4, and no ptr change occurs in RR mode.
  - On out_ready = 1: the same edge consumes idx 4 and accepts 8'h01; the next cycle shows out_idx = 0 with out_valid held at 1.
- Reset mid-operation.
  - Setup: RR_MODE = 1, ptr = 5, out_valid = 1 with out_ready = 0; assert rst with in_valid = 1.
  - Required: the next cycle shows out_valid = 0 and ptr = 0.
  - A following req = 8'hFF yields out_idx = 0.
- Width generality, N = 32, W = 5, RR_MODE = 1.
  - req = 32'h8000_0001 repeated gives out_idx = 0, 31, 0.
  - req = 32'h0001_0000 gives out_idx = 16 with out_multi = 0.

Source files
------------

// File: rtl/rr_priority_encoder_if.sv
// Request/result handshake bundle for rr_priority_encoder.
// The master side produces requests and consumes results; the slave side is the encoder.
interface rr_priority_encoder_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_none;
  logic         out_multi;

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_multi
  );

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_multi
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder, fixed or round-robin priority,
// with valid/ready on both sides and flags for all-zero and multi-hot requests.
module rr_priority_encoder #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter bit RR_MODE = 1'b0
) (
  input logic            clk,
  input logic            rst,
  rr_priority_encoder_if.slave bus
);

  generate
    if (N < 2 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("rr_priority_encoder: N must be a power of two in 2..64");
    end
    if (W != $clog2(N)) begin : g_bad_w
      $error("rr_priority_encoder: W must equal clog2(N)");
    end
  endgenerate

  logic [W-1:0]   ptr;
  logic [W-1:0]   scan_base;
  logic [2*N-1:0] scan_vec;
  logic [W-1:0]   idx_next;
  logic           found;
  logic           none_next;
  logic           multi_next;
  logic           in_ready;
  logic           accept;
  logic           out_valid_q;
  logic [W-1:0]   out_idx_q;
  logic           out_none_q;
  logic           out_multi_q;

  // Fixed mode is just a round-robin scan that always starts at bit 0.
  assign scan_base = RR_MODE ? ptr : '0;

  // Doubling the request lets a plain lowest-bit scan wrap past N-1 back to 0;
  // bits below the start pointer in the lower copy are masked off.
  always_comb begin
    scan_vec = {bus.req, bus.req};
    for (int i = 0; i < 2 * N; i++) begin
      if (i < int'(scan_base)) scan_vec[i] = 1'b0;
    end
  end

  // Truncating the doubled-range position to W bits reduces it mod N.
  always_comb begin
    idx_next = '0;
    found    = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && scan_vec[i]) begin
        found    = 1'b1;
        idx_next = W'(i);
      end
    end
  end

  assign none_next  = (bus.req == '0);
  assign multi_next = |(bus.req & (bus.req - N'(1)));

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_none_q  <= 1'b0;
      out_multi_q <= 1'b0;
      ptr         <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= idx_next;
        out_none_q  <= none_next;
        out_multi_q <= multi_next;
        if (RR_MODE && !none_next) ptr <= idx_next + W'(1);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_none  = out_none_q;
  assign bus.out_multi = out_multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: fixed 8-wide, round-robin 8-wide and
// round-robin 32-wide instances driven from one vector table plus handshake sequences.
module tb_rr_priority_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_priority_encoder_if #(.N(8),  .W(3)) bus_a ();
  rr_priority_encoder_if #(.N(8),  .W(3)) bus_b ();
  rr_priority_encoder_if #(.N(32), .W(5)) bus_c ();

  rr_priority_encoder #(.N(8),  .W(3), .RR_MODE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rr_priority_encoder #(.N(8),  .W(3), .RR_MODE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  rr_priority_encoder #(.N(32), .W(5), .RR_MODE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  typedef struct {
    int          sel;
    logic [31:0] req;
    int          idx;
    int          none;
    int          multi;
    int          ptr;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one instance for one clock and return at the following falling edge.
  task automatic applyStimulus(input int sel, input logic [31:0] reqv, input logic v, input logic r);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_c.in_valid = 1'b0;
    case (sel)
      0: begin bus_a.in_valid = v; bus_a.req = reqv[7:0]; bus_a.out_ready = r; end
      1: begin bus_b.in_valid = v; bus_b.req = reqv[7:0]; bus_b.out_ready = r; end
      default: begin bus_c.in_valid = v; bus_c.req = reqv; bus_c.out_ready = r; end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkState(input string tag, input int sel, input int e_valid, input int e_idx,
                            input int e_none, input int e_multi, input int e_inrdy, input int e_ptr);
    logic [31:0] v, ix, nn, mm, ir, pp;
    case (sel)
      0: begin
        v = 32'(bus_a.out_valid); ix = 32'(bus_a.out_idx); nn = 32'(bus_a.out_none);
        mm = 32'(bus_a.out_multi); ir = 32'(bus_a.in_ready); pp = 32'(dut_a.ptr);
      end
      1: begin
        v = 32'(bus_b.out_valid); ix = 32'(bus_b.out_idx); nn = 32'(bus_b.out_none);
        mm = 32'(bus_b.out_multi); ir = 32'(bus_b.in_ready); pp = 32'(dut_b.ptr);
      end
      default: begin
        v = 32'(bus_c.out_valid); ix = 32'(bus_c.out_idx); nn = 32'(bus_c.out_none);
        mm = 32'(bus_c.out_multi); ir = 32'(bus_c.in_ready); pp = 32'(dut_c.ptr);
      end
    endcase
    checkOutput({tag, ".out_valid"}, v,  32'(e_valid));
    checkOutput({tag, ".out_idx"},   ix, 32'(e_idx));
    checkOutput({tag, ".out_none"},  nn, 32'(e_none));
    checkOutput({tag, ".out_multi"}, mm, 32'(e_multi));
    checkOutput({tag, ".in_ready"},  ir, 32'(e_inrdy));
    checkOutput({tag, ".ptr"},       pp, 32'(e_ptr));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    for (int i = 0; i < 8; i++) vecs.push_back(vec_t'{0, 32'(1) << i, i, 0, 0, 0});
    vecs.push_back(vec_t'{0, 32'h00, 0, 1, 0, 0});
    vecs.push_back(vec_t'{0, 32'hA4, 2, 0, 1, 0});
    vecs.push_back(vec_t'{1, 32'h81, 0, 0, 1, 1});
    vecs.push_back(vec_t'{1, 32'h81, 7, 0, 1, 0});
    vecs.push_back(vec_t'{1, 32'h81, 0, 0, 1, 1});
    vecs.push_back(vec_t'{1, 32'h81, 7, 0, 1, 0});
    vecs.push_back(vec_t'{1, 32'h00, 0, 1, 0, 0});
    vecs.push_back(vec_t'{2, 32'h8000_0001, 0,  0, 1, 1});
    vecs.push_back(vec_t'{2, 32'h8000_0001, 31, 0, 1, 0});
    vecs.push_back(vec_t'{2, 32'h8000_0001, 0,  0, 1, 1});
    vecs.push_back(vec_t'{2, 32'h0001_0000, 16, 0, 0, 17});

    bus_a.in_valid = 1'b0; bus_a.req = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.req = '0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.req = '0; bus_c.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
    checkState("reset_a", 0, 0, 0, 0, 0, 1, 0);
    checkState("reset_b", 1, 0, 0, 0, 0, 1, 0);
    checkState("reset_c", 2, 0, 0, 0, 0, 1, 0);

    // Consecutive entries for the same instance are accepted back-to-back.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].req, 1'b1, 1'b1);
      checkState($sformatf("vec%0d", i), vecs[i].sel, 1, vecs[i].idx, vecs[i].none,
                 vecs[i].multi, 1, vecs[i].ptr);
    end

    $display("[TB] backpressure sequence");
    applyStimulus(1, 32'h10, 1'b1, 1'b1);
    checkState("bp_accept", 1, 1, 4, 0, 0, 1, 5);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h01, 1'b1, 1'b0);
      checkState($sformatf("bp_hold%0d", k), 1, 1, 4, 0, 0, 0, 5);
    end
    applyStimulus(1, 32'h01, 1'b1, 1'b1);
    checkState("bp_release", 1, 1, 0, 0, 0, 1, 1);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 32'h10, 1'b1, 1'b1);
    checkState("mr_setup", 1, 1, 4, 0, 0, 1, 5);
    applyStimulus(1, 32'h01, 1'b1, 1'b0);
    checkState("mr_hold", 1, 1, 4, 0, 0, 0, 5);
    rst = 1'b1;
    applyStimulus(1, 32'h01, 1'b1, 1'b0);
    rst = 1'b0;
    checkState("mr_reset", 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'hFF, 1'b1, 1'b1);
    checkState("mr_ff", 1, 1, 0, 0, 1, 1, 1);

    applyStimulus(1, 32'h00, 1'b0, 1'b1);
    checkOutput("drain.out_valid", 32'(bus_b.out_valid), 32'd0);
    checkOutput("drain.in_ready",  32'(bus_b.in_ready),  32'd1);
    checkOutput("drain.ptr",       32'(dut_b.ptr),       32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
